gate_sweep_driver: RTL and testbench
====================================

GATE_SWEEP_DRIVER -- requirements
Module: gate_sweep_driver

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, range 1..15: extra cycles each input combination is held before it is sampled.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset that is synchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request to begin a sweep; accepted only in IDLE.
REQ-005 The block SHALL have port busy  output  1  high while in DRIVE.
REQ-006 The block SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-007 The block SHALL have ports drv_in0, drv_in1, drv_in2  output  1 each  stimulus to the AOI21 under test.
REQ-008 The block SHALL have port dut_out  input  1  response of the gate under test.
REQ-009 The block SHALL have port truth_tbl  output  8  captured responses; bit i = dut_out for combination i.
REQ-010 The block SHALL have port err_count  output  4  mismatches against golden ~((in0&in1)|in2).
REQ-011 The block SHALL have port pass  output  1  high after done when err_count==0; held until next accepted start.

Function
REQ-012 Combination index i (3 bits) SHALL map to {drv_in2,drv_in1,drv_in0} = {i[0],i[1],i[2]}, i.e. in0 is the MSB.
REQ-013 The FSM SHALL have states IDLE, DRIVE, DONE; reset state IDLE.
REQ-014 IDLE with start=1 SHALL go to DRIVE with i=0, settle counter=0, and clear truth_tbl, err_count and pass.
REQ-015 In DRIVE each combination SHALL be driven for exactly SETTLE+1 cycles; dut_out is sampled at the edge ending the last of those cycles.
REQ-016 On each sample, truth_tbl[i] SHALL be written and err_count SHALL be incremented when dut_out differs from the golden value.
REQ-017 After sampling i=7, the FSM SHALL go to DONE for one cycle (done=1, pass updated) and then return to IDLE.
REQ-018 Start-accept to done latency SHALL be 8*(SETTLE+1)+1 cycles.
REQ-019 start SHALL be ignored in DRIVE and DONE, with no restart and no effect on counters.
REQ-020 In IDLE and DONE, drv_in0..2 SHALL be 0; in IDLE, truth_tbl, err_count and pass SHALL retain the last sweep's results.
REQ-021 err_count SHALL need no saturation (maximum 8 fits in 4 bits).

Reset
REQ-022 With reset=0 at an edge, the block SHALL go to IDLE with busy=0, done=0, drv_in*=0, truth_tbl=0, err_count=0, pass=0, and i and the settle counter cleared.
REQ-023 Reset asserted mid-sweep SHALL abort the sweep at the next edge, with no done pulse and no partial results retained.

Configuration
REQ-024 Macro GATE_SWEEP_DRIVER_FIRST_FAIL_EN, when defined, SHALL add outputs first_fail_vld (1 bit) and first_fail_idx (3 bits), which capture the index of the first mismatch in a sweep, are cleared at start-accept and reset, and are held until the next start.
REQ-025 Without GATE_SWEEP_DRIVER_FIRST_FAIL_EN, those ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package gate_sweep_pkg SHALL hold the state enum typedef, constant NUM_COMBOS=8, and the golden AOI21 function.
REQ-027 Sub-module gate_sweep_golden SHALL be used: a combinational golden AOI21 instantiated once and fed by the drive registers.

Verification
REQ-028 SETTLE=1 with a correct AOI21 attached: truth_tbl=8'h15, err_count=0, pass=1, and done 17 cycles after start-accept.
REQ-029 dut_out stuck at 0: truth_tbl=8'h00, err_count=3, pass=0; with the macro, first_fail_idx=0.
REQ-030 dut_out stuck at 1: truth_tbl=8'hFF, err_count=5, pass=0; with the macro, first_fail_idx=1.
REQ-031 DUT replaced by OR21 (~golden): truth_tbl=8'hEA, err_count=8; a second start pulse at cycle 4 SHALL be ignored, giving a single done.
REQ-032 Reset asserted at cycle 5 of a sweep: next cycle busy=0, drv_in*=0, truth_tbl=0, and no done pulse.
REQ-033 SETTLE=3 with a correct DUT: each combination SHALL be held for 4 cycles, with done 33 cycles after start-accept.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweep_pkg
// Shared types and helpers for the AOI21 gate sweep driver.
//   sweep_state_e : sweep controller state encoding
//   NUM_COMBOS    : number of input combinations swept (3 inputs)
//   golden_aoi21  : reference AOI21 function, ~((in0 & in1) | in2)
//   combo_drive   : combination index -> {in2, in1, in0}; in0 takes the index MSB
// -----------------------------------------------------------------------------
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    localparam int NUM_COMBOS = 8;
    localparam int IDX_W      = 3;

    function automatic logic golden_aoi21(input logic in0, input logic in1, input logic in2);
        return ~((in0 & in1) | in2);
    endfunction

    // Bit-reversed mapping: index bit 2 drives in0, index bit 0 drives in2.
    function automatic logic [2:0] combo_drive(input logic [IDX_W-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/gate_sweep_golden.sv
// -----------------------------------------------------------------------------
// gate_sweep_golden
// Combinational golden AOI21 used to judge the response of the gate under test.
// Ports:
//   in0, in1, in2 : input  - registered stimulus currently driven to the gate
//   golden        : output - expected AOI21 response for that stimulus
// -----------------------------------------------------------------------------
module gate_sweep_golden
    import gate_sweep_pkg::*;
(
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic golden
);

    always_comb begin
        golden = golden_aoi21(in0, in1, in2);
    end

endmodule

// File: rtl/gate_sweep_driver.sv
// -----------------------------------------------------------------------------
// gate_sweep_driver
// Walks all eight input combinations of an AOI21 gate under test, holds each
// for SETTLE+1 cycles, samples the gate response on the last of those cycles,
// records it in a truth table and counts mismatches against a golden AOI21.
//
// Parameter:
//   SETTLE (1..15)   : extra cycles each combination is held before sampling
// Ports:
//   clk              : input  - sole clock, rising edge
//   reset            : input  - synchronous, active-low
//   start            : input  - begin a sweep (accepted only in IDLE)
//   busy             : output - high while driving combinations
//   done             : output - one-cycle pulse at sweep completion
//   drv_in0..2       : output - stimulus to the gate under test
//   dut_out          : input  - response of the gate under test
//   truth_tbl[7:0]   : output - bit i = response sampled for combination i
//   err_count[3:0]   : output - number of mismatches in the last sweep
//   pass             : output - last sweep had no mismatch
//   first_fail_vld   : output - a mismatch was seen   (GATE_SWEEP_DRIVER_FIRST_FAIL_EN)
//   first_fail_idx   : output - index of first mismatch (GATE_SWEEP_DRIVER_FIRST_FAIL_EN)
//
// Optional feature macro: GATE_SWEEP_DRIVER_FIRST_FAIL_EN
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | outputs parked at 0, previous results held, waiting on start
// DRIVE | combination idx_q driven, settle counter running, sampling
// DONE  | one-cycle done pulse, results final, back to IDLE
// -----------------------------------------------------------------------------
module gate_sweep_driver
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       drv_in0,
    output logic       drv_in1,
    output logic       drv_in2,
    input  logic       dut_out,
    output logic [7:0] truth_tbl,
    output logic [3:0] err_count,
    output logic       pass
`ifdef GATE_SWEEP_DRIVER_FIRST_FAIL_EN
    ,
    output logic       first_fail_vld,
    output logic [2:0] first_fail_idx
`endif
);

    localparam logic [3:0]       SETTLE_TC  = 4'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_COMBO = IDX_W'(NUM_COMBOS - 1);

    sweep_state_e     state_q;
    sweep_state_e     state_nxt;

    logic [IDX_W-1:0] idx_q;
    logic [3:0]       settle_q;
    logic [2:0]       drv_q;        // {in2, in1, in0}
    logic [7:0]       truth_q;
    logic [3:0]       err_q;
    logic             pass_q;

    logic             golden_w;
    logic             mismatch;
    logic [3:0]       err_nxt;
    logic             settle_tc;
    logic             last_combo;
    logic             accept;
    logic             sample;

    gate_sweep_golden u_golden (
        .in0    (drv_q[0]),
        .in1    (drv_q[1]),
        .in2    (drv_q[2]),
        .golden (golden_w)
    );

    assign settle_tc  = (settle_q == SETTLE_TC);
    assign last_combo = (idx_q == LAST_COMBO);
    assign mismatch   = dut_out ^ golden_w;
    assign err_nxt    = err_q + {3'b000, mismatch};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                if (settle_tc) begin
                    sample = 1'b1;
                    if (last_combo) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Drive registers are loaded one edge ahead so the new combination is
    // already on the pins during the first of its SETTLE+1 hold cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q    <= '0;
            settle_q <= '0;
            drv_q    <= '0;
            truth_q  <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
        end else if (accept) begin
            idx_q    <= '0;
            settle_q <= '0;
            drv_q    <= combo_drive('0);
            truth_q  <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
        end else if (busy) begin
            if (sample) begin
                truth_q[idx_q] <= dut_out;
                err_q          <= err_nxt;
                if (last_combo) begin
                    drv_q  <= '0;
                    pass_q <= (err_nxt == 4'd0);
                end else begin
                    idx_q    <= idx_q + 1'b1;
                    settle_q <= '0;
                    drv_q    <= combo_drive(idx_q + 1'b1);
                end
            end else begin
                settle_q <= settle_q + 1'b1;
            end
        end
    end

`ifdef GATE_SWEEP_DRIVER_FIRST_FAIL_EN
    logic             ff_vld_q;
    logic [IDX_W-1:0] ff_idx_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ff_vld_q <= 1'b0;
            ff_idx_q <= '0;
        end else if (accept) begin
            ff_vld_q <= 1'b0;
            ff_idx_q <= '0;
        end else if (sample && mismatch && !ff_vld_q) begin
            ff_vld_q <= 1'b1;
            ff_idx_q <= idx_q;
        end
    end

    assign first_fail_vld = ff_vld_q;
    assign first_fail_idx = ff_idx_q;
`else
    // No first-fail tracking in this build.
`endif

    assign drv_in0   = drv_q[0];
    assign drv_in1   = drv_q[1];
    assign drv_in2   = drv_q[2];
    assign truth_tbl = truth_q;
    assign err_count = err_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_gate_sweep_driver.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_driver
// Two sweep drivers (SETTLE=1 and SETTLE=3) share start/reset and each drives
// its own copy of a table-defined gate under test. Stimulus pushes expected
// sweep results into per-instance queues; a negedge monitor pops and compares
// when done is seen, and also checks the per-cycle drive sequence.
// -----------------------------------------------------------------------------
module tb_gate_sweep_driver;

    localparam int NI = 2;
    localparam int S0 = 1;
    localparam int S1 = 3;

    typedef struct {
        logic [7:0] truth;
        int         err;
        logic       pass;
        int         accept_cyc;
        logic       ff_vld;
        int         ff_idx;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;

    logic [NI-1:0]      busy_w;
    logic [NI-1:0]      done_w;
    logic [NI-1:0]      d0;
    logic [NI-1:0]      d1;
    logic [NI-1:0]      d2;
    logic [NI-1:0]      dout;
    logic [NI-1:0]      pass_w;
    logic [NI-1:0][7:0] truth_w;
    logic [NI-1:0][3:0] err_w;
`ifdef GATE_SWEEP_DRIVER_FIRST_FAIL_EN
    logic [NI-1:0]      ffv_w;
    logic [NI-1:0][2:0] ffi_w;
`endif

    // Response of the gate under test, indexed by combination number.
    logic [7:0] resp_tbl = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last_exp[NI];
    exp_t mon_e;
    logic [NI-1:0] post_done = '0;
    int   trace[NI][64];
    int   tl[NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_gate
        assign dout[g] = resp_tbl[{d0[g], d1[g], d2[g]}];
    end

    gate_sweep_driver #(.SETTLE(S0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy_w[0]),
        .done      (done_w[0]),
        .drv_in0   (d0[0]),
        .drv_in1   (d1[0]),
        .drv_in2   (d2[0]),
        .dut_out   (dout[0]),
        .truth_tbl (truth_w[0]),
        .err_count (err_w[0]),
        .pass      (pass_w[0])
`ifdef GATE_SWEEP_DRIVER_FIRST_FAIL_EN
        ,
        .first_fail_vld (ffv_w[0]),
        .first_fail_idx (ffi_w[0])
`endif
    );

    gate_sweep_driver #(.SETTLE(S1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy_w[1]),
        .done      (done_w[1]),
        .drv_in0   (d0[1]),
        .drv_in1   (d1[1]),
        .drv_in2   (d2[1]),
        .dut_out   (dout[1]),
        .truth_tbl (truth_w[1]),
        .err_count (err_w[1]),
        .pass      (pass_w[1])
`ifdef GATE_SWEEP_DRIVER_FIRST_FAIL_EN
        ,
        .first_fail_vld (ffv_w[1]),
        .first_fail_idx (ffi_w[1])
`endif
    );

    function automatic int settle_of(input int k);
        return (k == 0) ? S0 : S1;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%0d expected=%0d", name, k, $signed(act), $signed(exp));
        end
    endtask

    // Reference model: AOI21 from its boolean definition, in0 = index MSB.
    function automatic exp_t build_exp(input logic [7:0] resp, input int acc);
        exp_t e;
        logic [7:0] gold;
        logic [7:0] diff;
        for (int i = 0; i < 8; i++) begin
            int in0;
            int in1;
            int in2;
            in0 = (i >> 2) & 1;
            in1 = (i >> 1) & 1;
            in2 = i & 1;
            gold[i] = !((in0 == 1 && in1 == 1) || in2 == 1);
        end
        diff         = resp ^ gold;
        e.truth      = resp;
        e.err        = $countones(diff);
        e.pass       = (e.err == 0);
        e.accept_cyc = acc;
        e.ff_vld     = (diff != 8'h00);
        e.ff_idx     = 0;
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) e.ff_idx = i;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (post_done[k]) begin
                check("retain_busy",  k, 32'(busy_w[k]),  0);
                check("retain_truth", k, 32'(truth_w[k]), 32'(last_exp[k].truth));
                check("retain_err",   k, 32'(err_w[k]),   32'(last_exp[k].err));
                check("retain_pass",  k, 32'(pass_w[k]),  32'(last_exp[k].pass));
                post_done[k] = 1'b0;
            end
            if (busy_w[k]) begin
                if (tl[k] < 64) begin
                    trace[k][tl[k]] = int'({d0[k], d1[k], d2[k]});
                    tl[k]++;
                end
            end else if (done_w[k]) begin
                logic empty;
                empty = 1'b0;
                if (k == 0) begin
                    if (q0.size() == 0) empty = 1'b1; else mon_e = q0.pop_front();
                end else begin
                    if (q1.size() == 0) empty = 1'b1; else mon_e = q1.pop_front();
                end
                if (empty) begin
                    check("unexpected_done", k, 1, 0);
                end else begin
                    int s;
                    int bad;
                    s   = settle_of(k);
                    bad = -1;
                    for (int j = 0; j < tl[k]; j++) begin
                        if (trace[k][j] != j / (s + 1) && bad < 0) bad = j;
                    end
                    check("truth_tbl", k, 32'(truth_w[k]), 32'(mon_e.truth));
                    check("err_count", k, 32'(err_w[k]),   32'(mon_e.err));
                    check("pass",      k, 32'(pass_w[k]),  32'(mon_e.pass));
                    check("latency",   k, 32'(cyc - mon_e.accept_cyc + 1), 32'(8 * (s + 1) + 1));
                    check("done_drv",  k, 32'({d0[k], d1[k], d2[k]}), 0);
                    check("hold_len",  k, 32'(tl[k]), 32'(8 * (s + 1)));
                    check("drive_seq", k, 32'(bad), 32'(-1));
`ifdef GATE_SWEEP_DRIVER_FIRST_FAIL_EN
                    check("ff_vld", k, 32'(ffv_w[k]), 32'(mon_e.ff_vld));
                    if (mon_e.ff_vld) check("ff_idx", k, 32'(ffi_w[k]), 32'(mon_e.ff_idx));
`endif
                    last_exp[k]  = mon_e;
                    post_done[k] = 1'b1;
                end
                tl[k] = 0;
            end else begin
                tl[k] = 0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 300 && (q0.size() != 0 || q1.size() != 0 || busy_w != '0 || done_w != '0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("sweep_timeout", 0, 1, 0);
        repeat (2) @(negedge clk);
    endtask

    // spur: cycle after accept at which a second start is sampled (-1 none)
    // rst : cycle after accept at which reset is sampled low (-1 none)
    task automatic run_sweep(input logic [7:0] resp, input int spur, input int rst);
        int acc;
        exp_t e;
        @(negedge clk);
        resp_tbl = resp;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc   = cyc;
        for (int k = 0; k < NI; k++) begin
            check("accept_busy",  k, 32'(busy_w[k]),  1);
            check("accept_truth", k, 32'(truth_w[k]), 0);
            check("accept_err",   k, 32'(err_w[k]),   0);
            check("accept_pass",  k, 32'(pass_w[k]),  0);
`ifdef GATE_SWEEP_DRIVER_FIRST_FAIL_EN
            check("accept_ffv",   k, 32'(ffv_w[k]),   0);
`endif
        end
        e = build_exp(resp, acc);
        q0.push_back(e);
        q1.push_back(e);
        if (rst > 0) begin
            for (int j = 1; j < rst; j++) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk);
            #1;
            reset = 1'b1;
            for (int k = 0; k < NI; k++) begin
                check("abort_busy",  k, 32'(busy_w[k]),  0);
                check("abort_done",  k, 32'(done_w[k]),  0);
                check("abort_drv",   k, 32'({d0[k], d1[k], d2[k]}), 0);
                check("abort_truth", k, 32'(truth_w[k]), 0);
                check("abort_err",   k, 32'(err_w[k]),   0);
                check("abort_pass",  k, 32'(pass_w[k]),  0);
            end
            q0.delete();
            q1.delete();
            repeat (40) @(negedge clk);
        end else if (spur > 0) begin
            for (int j = 1; j < spur; j++) @(posedge clk);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        for (int k = 0; k < NI; k++) tl[k] = 0;
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_busy",  k, 32'(busy_w[k]),  0);
            check("rst_done",  k, 32'(done_w[k]),  0);
            check("rst_drv",   k, 32'({d0[k], d1[k], d2[k]}), 0);
            check("rst_truth", k, 32'(truth_w[k]), 0);
            check("rst_err",   k, 32'(err_w[k]),   0);
            check("rst_pass",  k, 32'(pass_w[k]),  0);
        end
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        run_sweep(8'h15, -1, -1);   // correct AOI21
        run_sweep(8'h00, -1, -1);   // stuck at 0
        run_sweep(8'hFF, -1, -1);   // stuck at 1
        run_sweep(8'hEA,  4, -1);   // OR21, second start ignored
        run_sweep(8'($urandom), -1, 5);
        run_sweep(8'h15, -1, -1);
        for (int r = 0; r < 10; r++) begin
            int sp;
            sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : -1;
            run_sweep(8'($urandom), sp, -1);
        end

        if (q0.size() != 0 || q1.size() != 0) check("missing_done", 0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
